// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt issuer: source count, payload width,
// FSM states and the one-hot source encodings (A is the MSB).
package interrupt_pkg;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [NUM_SRC-1:0] SRC_NONE = 4'b0000;
  localparam logic [NUM_SRC-1:0] SRC_A    = 4'b1000;
  localparam logic [NUM_SRC-1:0] SRC_B    = 4'b0100;
  localparam logic [NUM_SRC-1:0] SRC_C    = 4'b0010;
  localparam logic [NUM_SRC-1:0] SRC_D    = 4'b0001;

  typedef logic [NUM_SRC-1:0][DATA_W-1:0] payload_t;

  // AND-OR mux of the payload bank by a one-hot select; zero when nothing is selected.
  function automatic logic [DATA_W-1:0] pick_payload(input logic [NUM_SRC-1:0] sel,
                                                     input payload_t           bank);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel[i]) res = res | bank[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: one-hot grant for the highest set pending bit (source A = MSB wins).
module irq_priority_enc
  import interrupt_pkg::*;
(
  input  logic [NUM_SRC-1:0] pending_i,
  output logic [NUM_SRC-1:0] grant_o
);

  // NOTE: combinational outputs get a default before any conditional assignment so no latch is inferred.
  always_comb begin
    grant_o = SRC_NONE;
    // Ascending scan: the last (highest) set bit overwrites lower ones.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_i[i]) grant_o = NUM_SRC'(1) << i;
    end
  end

endmodule

// File: rtl/interrupt_issuer.sv
// Latches per-source events with payloads, issues them one at a time by fixed priority
// and waits for ack. Optional macro IRQ_TIMEOUT_EN adds an ISSUE timeout of TIMEOUT_CYCLES.
module interrupt_issuer
  import interrupt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] event_i,
  input  logic [DATA_W-1:0]  a_i,
  input  logic [DATA_W-1:0]  b_i,
  input  logic [DATA_W-1:0]  c_i,
  input  logic [DATA_W-1:0]  d_i,
  input  logic               ack_i,
  input  logic               overrun_clr_i,
  output logic [NUM_SRC-1:0] interrupt_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [NUM_SRC-1:0] overrun_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  payload_t           payload_q, payload_in;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] irq_d;
  logic [DATA_W-1:0]  data_d;
  logic               ack_take;
  logic [NUM_SRC-1:0] clr_mask, ovr_set, capture;

  assign payload_in = {a_i, b_i, c_i, d_i};

  // interrupt_o doubles as the latched current source while in ISSUE.
  assign ack_take = (state_q == ISSUE) && ack_i;
  assign clr_mask = ack_take ? interrupt_o : SRC_NONE;

  // An event on a still-pending source is an overrun unless that source is being acked now.
  assign ovr_set   = event_i & pending_q & ~clr_mask;
  assign capture   = event_i & ~ovr_set;
  assign pending_d = (pending_q & ~clr_mask) | event_i;

  irq_priority_enc u_prio (
    .pending_i (pending_q),
    .grant_o   (grant)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_o <= '0;
      // NOTE: the payload bank is reset so data_o can never expose values from before reset.
      payload_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_o <= (overrun_o & ~{NUM_SRC{overrun_clr_i}}) | ovr_set;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (capture[s]) payload_q[s] <= payload_in[s];
      end
    end
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    irq_d   = interrupt_o;
    data_d  = data_o;
`ifdef IRQ_TIMEOUT_EN
    tmo_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = ISSUE;
          irq_d   = grant;
          data_d  = pick_payload(grant, payload_q);
        end
      end
      ISSUE: begin
        if (ack_i) begin
          state_d = GAP;
          irq_d   = SRC_NONE;
          data_d  = '0;
        end
`ifdef IRQ_TIMEOUT_EN
        // Timeout leaves pending set so the source competes again at the next arbitration.
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = GAP;
          irq_d   = SRC_NONE;
          data_d  = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      GAP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        irq_d   = SRC_NONE;
        data_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      interrupt_o <= SRC_NONE;
      data_o      <= '0;
    end else begin
      state_q     <= state_d;
      interrupt_o <= irq_d;
      data_o      <= data_d;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_interrupt_issuer.sv
// Directed self-checking bench for interrupt_issuer; covers both IRQ_TIMEOUT_EN builds.
module tb_interrupt_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] event_i;
  logic [7:0] a_i, b_i, c_i, d_i;
  logic       ack_i;
  logic       overrun_clr_i;
  logic [3:0] interrupt_o;
  logic [7:0] data_o;
  logic [3:0] overrun_o;

  int n_checks = 0;
  int n_pass   = 0;

  interrupt_issuer #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .event_i       (event_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .c_i           (c_i),
    .d_i           (d_i),
    .ack_i         (ack_i),
    .overrun_clr_i (overrun_clr_i),
    .interrupt_o   (interrupt_o),
    .data_o        (data_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int drop;
    rst_n = 1'b0; event_i = '0; a_i = '0; b_i = '0; c_i = '0; d_i = '0;
    ack_i = 1'b0; overrun_clr_i = 1'b0;

    #12;
    check("rst_irq", interrupt_o, 4'b0000);
    check("rst_data", data_o, 8'h00);
    check("rst_ovr", overrun_o, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("idle_irq", interrupt_o, 4'b0000);

    // Single event on C: one-edge latency, stable while issued, ack clears.
    event_i = 4'b0010; c_i = 8'h5A; tick(); event_i = '0; c_i = '0;
    check("lat_edge_k", interrupt_o, 4'b0000);
    tick();
    check("c_irq", interrupt_o, 4'b0010);
    check("c_data", data_o, 8'h5A);
    tick(); tick();
    check("c_stable_irq", interrupt_o, 4'b0010);
    check("c_stable_data", data_o, 8'h5A);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    check("c_ack_irq", interrupt_o, 4'b0000);
    check("c_ack_data", data_o, 8'h00);
    tick(); tick();
    check("c_no_reissue", interrupt_o, 4'b0000);

    // A and D together: A first; ack held through GAP/IDLE is ignored; no preemption of D.
    event_i = 4'b1001; a_i = 8'hAA; d_i = 8'hDD; tick(); event_i = '0;
    tick();
    check("ad_first_irq", interrupt_o, 4'b1000);
    check("ad_first_data", data_o, 8'hAA);
    ack_i = 1'b1; tick();
    check("ad_ack_irq", interrupt_o, 4'b0000);
    tick();
    check("ad_gap_irq", interrupt_o, 4'b0000);
    tick();
    ack_i = 1'b0;
    check("ad_second_irq", interrupt_o, 4'b0001);
    check("ad_second_data", data_o, 8'hDD);
    event_i = 4'b1000; a_i = 8'hA1; tick(); event_i = '0;
    check("no_preempt_irq", interrupt_o, 4'b0001);
    check("no_preempt_data", data_o, 8'hDD);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    tick(); tick();
    check("late_a_irq", interrupt_o, 4'b1000);
    check("late_a_data", data_o, 8'hA1);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    tick(); tick();
    check("ovr_clean", overrun_o, 4'b0000);

    // Overrun on B: payload kept, set wins over clear, clear alone wipes it.
    event_i = 4'b0100; b_i = 8'h11; tick(); event_i = '0;
    tick();
    check("b_irq", interrupt_o, 4'b0100);
    event_i = 4'b0100; b_i = 8'h22; tick(); event_i = '0;
    check("b_ovr", overrun_o, 4'b0100);
    check("b_data_kept", data_o, 8'h11);
    event_i = 4'b0100; b_i = 8'h33; overrun_clr_i = 1'b1; tick();
    event_i = '0; overrun_clr_i = 1'b0;
    check("b_set_wins", overrun_o, 4'b0100);
    overrun_clr_i = 1'b1; tick(); overrun_clr_i = 1'b0;
    check("b_ovr_clr", overrun_o, 4'b0000);
    check("b_data_still", data_o, 8'h11);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    tick(); tick();
    check("b_done", interrupt_o, 4'b0000);

    // Event and ack on A at the same edge: re-issued with the new payload, no overrun.
    event_i = 4'b1000; a_i = 8'h01; tick(); event_i = '0;
    tick();
    check("a1_data", data_o, 8'h01);
    event_i = 4'b1000; a_i = 8'h02; ack_i = 1'b1; tick(); event_i = '0; ack_i = 1'b0;
    check("a_same_edge_irq", interrupt_o, 4'b0000);
    check("a_same_edge_ovr", overrun_o, 4'b0000);
    tick(); tick();
    check("a2_irq", interrupt_o, 4'b1000);
    check("a2_data", data_o, 8'h02);
    check("a2_ovr", overrun_o, 4'b0000);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    tick(); tick();

    // No ack: timeout build re-issues after 16 cycles, default build holds.
    event_i = 4'b0010; c_i = 8'hC3; tick(); event_i = '0;
    tick();
    check("hold_irq", interrupt_o, 4'b0010);
`ifdef IRQ_TIMEOUT_EN
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (interrupt_o === 4'b0010) hi++;
      else break;
    end
    check("tmo_high_cycles", hi, 16);
    check("tmo_gap_irq", interrupt_o, 4'b0000);
    tick();
    check("tmo_idle_irq", interrupt_o, 4'b0000);
    tick();
    check("tmo_reissue_irq", interrupt_o, 4'b0010);
    check("tmo_reissue_data", data_o, 8'hC3);
`else
    drop = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (interrupt_o !== 4'b0010) drop++;
    end
    check("hold_drops", drop, 0);
    check("hold_data", data_o, 8'hC3);
`endif
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    tick(); tick();

    // Asynchronous reset mid-ISSUE discards pending D.
    event_i = 4'b1001; a_i = 8'h05; d_i = 8'h06; tick(); event_i = '0;
    tick();
    check("pre_rst_irq", interrupt_o, 4'b1000);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_irq", interrupt_o, 4'b0000);
    check("async_rst_data", data_o, 8'h00);
    #2 rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_quiet", interrupt_o, 4'b0000);
    event_i = 4'b0001; d_i = 8'h77; tick(); event_i = '0;
    tick();
    check("post_rst_irq", interrupt_o, 4'b0001);
    check("post_rst_data", data_o, 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_issuer.md
INTERRUPT_ISSUER -- requirements
Module: interrupt_issuer

Interface
REQ-001 The block SHALL take parameter TIMEOUT_CYCLES, default 16: cycles ISSUE waits for ack_i before re-arbitrating (used only with IRQ_TIMEOUT_EN).
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 event_i  input  4  per-source event strobe, sampled each rising edge; bit3 = source A ... bit0 = source D.
REQ-006 a_i, b_i, c_i, d_i  input  8 each  payload for sources A..D, captured with the event.
REQ-007 ack_i  input  1  consumer acknowledge of the currently issued interrupt.
REQ-008 overrun_clr_i  input  1  clears all overrun flags.
REQ-009 interrupt_o  output  4  one-hot issued interrupt, or 4'b0000 when none is issued.
REQ-010 data_o  output  8  payload of the issued source; 8'h00 when interrupt_o is 0.
REQ-011 overrun_o  output  4  sticky per-source overrun flags.

Function
REQ-012 Each source SHALL have a pending bit and an 8-bit payload register; event_i[s] high at edge k sets pending[s] and captures the payload after edge k.
REQ-013 An event on an already-pending source SHALL set overrun_o[s] and SHALL NOT overwrite the stored payload.
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and GAP.
REQ-015 IDLE -> ISSUE SHALL occur when any pending bit is set; the winner is the highest set bit (A > B > C > D) and is latched as the current source.
REQ-016 In ISSUE, interrupt_o SHALL be one-hot for the current source and data_o SHALL hold its payload; both are registered and stable for the whole state.
REQ-017 Latency: an event sampled at edge k with the FSM in IDLE SHALL show interrupt_o high after edge k+1.
REQ-018 An ack_i sampled high in ISSUE at edge m SHALL clear pending of the current source, drive interrupt_o and data_o to 0, and enter GAP after edge m.
REQ-019 GAP SHALL last exactly one cycle, then go to IDLE, which guarantees at least one 4'b0000 cycle between issues.
REQ-020 ack_i outside ISSUE SHALL be ignored.
REQ-021 An event and an ack for the current source at the same edge SHALL leave pending set, capture the new payload, and not flag overrun.
REQ-022 Arrival of a higher-priority event during ISSUE SHALL NOT preempt; it is served at the next arbitration.
REQ-023 If overrun_clr_i and an overrun-setting event occur at the same edge, the set SHALL win for that source.

Reset
REQ-024 While rst_n is low: state = IDLE, all pending, payload and overrun bits = 0, interrupt_o = 4'b0000, data_o = 8'h00, timeout counter = 0.
REQ-025 Reset asserted mid-ISSUE SHALL drop interrupt_o to 0 immediately (asynchronously) and discard all pending events.

Configuration
REQ-026 Macro IRQ_TIMEOUT_EN defined: a counter SHALL run in ISSUE; after TIMEOUT_CYCLES cycles without ack the FSM SHALL enter GAP with pending left set, then re-arbitrate.
REQ-027 Macro IRQ_TIMEOUT_EN undefined: ISSUE SHALL wait indefinitely for ack_i, and no counter logic is present.

Structure
REQ-028 Package interrupt_pkg SHALL hold NUM_SRC=4, DATA_W=8, the state enum (IDLE, ISSUE, GAP) and the one-hot source encodings.
REQ-029 Priority selection SHALL be a sub-module irq_priority_enc (4-bit pending in, one-hot grant out, A highest).

Verification
REQ-030 event_i=4'b0010, c_i=8'h5A at edge 1 -> interrupt_o=4'b0010 and data_o=8'h5A after edge 2; ack at edge 5 -> 4'b0000 after edge 5.
REQ-031 event_i=4'b1001 at the same edge -> A issued first; after ack + GAP, D issued with its captured payload.
REQ-032 Two events on B before ack (b_i=8'h11, then 8'h22) -> overrun_o=4'b0100, data_o=8'h11; overrun_clr_i -> overrun_o=0.
REQ-033 Event on A and ack at the same edge while A is issued -> after GAP, A re-issued with the new payload; overrun_o stays 0.
REQ-034 With IRQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> interrupt_o drops after 16 cycles, one GAP cycle, then re-issues; without the macro, interrupt_o holds for 100+ cycles.
REQ-035 rst_n low mid-ISSUE -> interrupt_o=0 without waiting for a clock edge; after release, no issue occurs until a new event.
